// File: rtl/ah_lru_arbiter_param.sv
// Parametrised least-recently-used arbiter with a registered one-hot grant,
// optional grant locking until release, downstream back-pressure and a hold watchdog.
module ah_lru_arbiter_param #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned LOCK_EN  = 1,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rel,
  input  logic               gnt_busy,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_vld,
  output logic [IDW-1:0]     gnt_id,
  output logic               timeout
);

  localparam int unsigned    HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0]  HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [HW-1:0]  HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit             LOCKED    = (LOCK_EN != 0);
  localparam bit             WDOG_EN   = LOCKED && (MAX_HOLD > 0);
  localparam logic [IDW-1:0] RANK_TOP  = IDW'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_e;

  state_e               state_q;
  logic [IDW-1:0]       rank_q [NUM_REQ];
  logic [IDW-1:0]       rank_d [NUM_REQ];
  logic [HW-1:0]        hold_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IDW-1:0]       gnt_id_q;
  logic                 gnt_vld_q;
  logic                 timeout_q;

  logic                 rel_hit;
  logic                 drop_hit;
  logic                 wd_hit;
  logic                 release_c;
  logic                 timeout_c;
  logic                 can_launch;
  logic                 launch;
  logic                 found;
  logic [NUM_REQ-1:0]   mask;
  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   win_oh;
  logic [IDW-1:0]       win_id;
  logic [IDW-1:0]       win_rank;

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_id  = gnt_id_q;
  assign timeout = timeout_q;

  always_comb begin
    rel_hit    = LOCKED && rel;
    drop_hit   = !req[gnt_id_q];
    wd_hit     = WDOG_EN && (hold_q == HOLD_LAST);
    release_c  = (state_q == ST_GRANT) && (rel_hit || drop_hit || wd_hit);
    timeout_c  = (state_q == ST_GRANT) && wd_hit && !rel_hit && !drop_hit;
    can_launch = !LOCKED || (state_q == ST_IDLE) || release_c;

    // A requester released by the watchdog sits out the same-cycle relaunch.
    mask = '0;
    if (timeout_c) begin
      mask[gnt_id_q] = 1'b1;
    end
    cand = req & ~mask;

    found    = 1'b0;
    win_id   = '0;
    win_rank = '1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (cand[i] && (!found || (rank_q[i] < win_rank))) begin
        found    = 1'b1;
        win_id   = IDW'(i);
        win_rank = rank_q[i];
      end
    end
    win_oh         = '0;
    win_oh[win_id] = 1'b1;

    launch = can_launch && found && !gnt_busy;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rank_d[i] = rank_q[i];
      if (launch) begin
        if (IDW'(i) == win_id) begin
          rank_d[i] = RANK_TOP;
        end else if (rank_q[i] > win_rank) begin
          rank_d[i] = rank_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rank_q[i] <= IDW'(i);
      end
    end else begin
      rank_q    <= rank_d;
      timeout_q <= timeout_c;
      if (launch) begin
        gnt_q     <= win_oh;
        gnt_id_q  <= win_id;
        gnt_vld_q <= 1'b1;
        hold_q    <= '0;
        state_q   <= LOCKED ? ST_GRANT : ST_IDLE;
      end else if ((state_q == ST_GRANT) && !release_c) begin
        if (hold_q != HOLD_SAT) begin
          hold_q <= hold_q + 1'b1;
        end
      end else begin
        gnt_q     <= '0;
        gnt_id_q  <= '0;
        gnt_vld_q <= 1'b0;
        state_q   <= ST_IDLE;
      end
    end
  end

endmodule
